spi_master_ctrl: RTL
====================

// Module: spi_master_ctrl
// PURPOSE
//  Initiator end of the SPI slave/RAM link. Serialises 10-bit command words
//  (cmd[9:8] + payload[7:0]) onto MOSI under SS_n, using the shared system clk
//  (no SCLK). For read-data frames it captures the 8-bit reply on MISO.
//  Sits between the test host/CPU side and the SPI slave.
// PARAMETERS
//  FRAME_W  10  command word width shifted on MOSI
//  DATA_W   8   read-data width captured from MISO
//  RD_LAT   2   cycles from last MOSI bit to first valid MISO bit (1..7)
//  GAP_CYC  1   minimum SS_n-high cycles between frames (1..7)
// PORTS
//  clk      in   1        system clock; all logic on rising edge
//  rst      in   1        synchronous, active-high reset
//  start    in   1        request frame; sampled only when busy=0
//  tx_word  in   FRAME_W  command word; latched on accepted start
//  busy     out  1        high from start-accept edge until GAP ends
//  done     out  1        1-cycle pulse on the first SS_n-high cycle after a frame
//  rd_valid out  1        pulses with done for cmd 2'b11 frames only
//  rd_data  out  DATA_W   read byte; holds until next read frame completes
//  SS_n     out  1        slave select, active low, registered
//  MOSI     out  1        serial data to slave, registered, MSB first
//  MISO     in   1        serial data from slave
// BEHAVIOUR
//  Reset: SS_n=1, MOSI=0, busy=0, done=0, rd_valid=0, rd_data=0, state=IDLE.
//  Reset mid-frame: SS_n high on the next edge; no done pulse; word discarded.
//  Commands: 00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data.
//  FSM: IDLE -> ARM -> SEL -> SHIFT -> [WAIT -> READ] -> GAP -> IDLE.
//  IDLE: start=1 at edge k latches tx_word; SS_n=0, busy=1 from cycle k+1.
//  ARM: 1 cycle, MOSI=0 (slave leaves IDLE).
//  SEL: 1 cycle, MOSI=word[9] (slave decodes read/write).
//  SHIFT: FRAME_W cycles, MOSI=word[9]..word[0], one bit per cycle.
//  Non-read frame: after SHIFT goes to GAP; SS_n low for exactly 12 cycles.
//  cmd 11: WAIT RD_LAT cycles (MOSI=0), then READ for DATA_W cycles, shifting
//   MISO MSB-first into rd_data shadow; SS_n low for 12+RD_LAT+8 cycles.
//  GAP: SS_n=1, MOSI=0 for GAP_CYC cycles; done (and rd_valid) pulse in first
//   GAP cycle; rd_data updates in that same cycle; busy drops after GAP.
//  start while busy=1: ignored, not queued. start held high in the last GAP
//   cycle is accepted on the next edge (back-to-back frames).
//  Bit counter 4 bits, saturates/reloads per phase; no wrap within a phase.
// CONFIGURATION
//  SPI_MASTER_ABORT_EN defined: adds input 'abort' (1 bit) and output
//   'aborted' (1 bit). abort=1 while busy in ARM..READ: next edge forces SS_n=1
//   and GAP; done pulses with aborted=1, rd_valid=0, rd_data unchanged.
//   abort in IDLE/GAP is ignored. aborted resets to 0 and clears on next accept.
//  Not defined: ports absent; frames always run to completion.
// STRUCTURE
//  spi_pkg: state enum (IDLE,ARM,SEL,SHIFT,WAIT,READ,GAP), command codes
//   CMD_WR_ADDR/CMD_WR_DATA/CMD_RD_ADDR/CMD_RD_DATA, phase length constants.
//  Sub-module spi_shift_reg: parallel-load/serial-out MOSI shifter plus
//   serial-in MISO capture register; FSM and counters stay in the top.
// TESTING
//  1 write addr: tx_word=10'h0A5 -> MOSI 0 then 0,0,1,0,1,0,0,1,0,1; SS_n low 12
//    cycles; done at cycle 13; rd_valid=0.
//  2 read data: tx_word=10'h300, slave returns 8'hC3 -> rd_data=8'hC3,
//    rd_valid=done=1 together; SS_n low 22 cycles (RD_LAT=2).
//  3 start while busy with 10'h1FF -> ignored; only first frame on MOSI; one done.
//  4 back-to-back: start held high -> second frame SS_n falls after exactly
//    GAP_CYC high cycles.
//  5 rst=1 at SHIFT bit 4 -> SS_n=1 next edge, busy=0, no done; new start ok.
//  6 (SPI_MASTER_ABORT_EN) abort in READ bit 3 -> SS_n=1 next edge,
//    done=aborted=1, rd_valid=0, rd_data keeps prior value.

Source files
------------

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - state encoding, command codes and phase lengths for the SPI master
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        SEL,
        SHIFT,
        WAIT,
        READ,
        GAP
    } spi_state_t;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    localparam int FRAME_W_DEF = 10;
    localparam int DATA_W_DEF  = 8;
    localparam int RD_LAT_DEF  = 2;
    localparam int GAP_CYC_DEF = 1;

    // The phase counter counts down to zero, so a phase of len cycles loads len-1.
    function automatic logic [3:0] phase_load(input int len);
        return 4'(len - 1);
    endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// rtl/spi_shift_reg.sv - MOSI parallel-load shifter and MISO serial capture register
module spi_shift_reg #(
    parameter int FRAME_W = 10,
    parameter int DATA_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               shift_tx,
    input  logic               shift_rx,
    input  logic [FRAME_W-1:0] tx_word,
    input  logic               miso,
    output logic               tx_msb,
    output logic [DATA_W-1:0]  rx_next
);

    logic [FRAME_W-1:0] tx_sr;
    // Only DATA_W-1 bits are stored; the final bit is taken live from miso.
    logic [DATA_W-2:0]  rx_sr;

    assign tx_msb  = tx_sr[FRAME_W-1];
    assign rx_next = {rx_sr, miso};

    // Load the command word on accept, shift it left MSB-first; shift MISO in.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_sr <= '0;
            rx_sr <= '0;
        end else begin
            if (load) begin
                tx_sr <= tx_word;
            end else if (shift_tx) begin
                tx_sr <= {tx_sr[FRAME_W-2:0], 1'b0};
            end
            if (shift_rx) begin
                rx_sr <= rx_next[DATA_W-2:0];
            end
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - SPI master frame FSM; optional abort via SPI_MASTER_ABORT_EN
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int FRAME_W = FRAME_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int RD_LAT  = RD_LAT_DEF,
    parameter int GAP_CYC = GAP_CYC_DEF
) (
    input  logic               clk,
    input  logic               rst,
`ifdef SPI_MASTER_ABORT_EN
    input  logic               abort,
    output logic               aborted,
`endif
    input  logic               start,
    input  logic [FRAME_W-1:0] tx_word,
    output logic               busy,
    output logic               done,
    output logic               rd_valid,
    output logic [DATA_W-1:0]  rd_data,
    output logic               SS_n,
    output logic               MOSI,
    input  logic               MISO
);

    localparam logic [3:0] SHIFT_LOAD = phase_load(FRAME_W);
    localparam logic [3:0] WAIT_LOAD  = phase_load(RD_LAT);
    localparam logic [3:0] READ_LOAD  = phase_load(DATA_W);
    localparam logic [3:0] GAP_LOAD   = phase_load(GAP_CYC);

    spi_state_t        state;
    logic [3:0]        cnt;
    logic [1:0]        cmd;
    logic              accept;
    logic              shift_tx;
    logic              shift_rx;
    logic              tx_msb;
    logic [DATA_W-1:0] rx_next;
`ifdef SPI_MASTER_ABORT_EN
    logic              abort_hit;
`endif

    // Shifter strobes: accept from IDLE or the last GAP cycle, shift in SEL/SHIFT/READ.
    always_comb begin
        accept   = start && ((state == IDLE) || ((state == GAP) && (cnt == 4'd0)));
        shift_tx = (state == SEL) || ((state == SHIFT) && (cnt != 4'd0));
        shift_rx = (state == READ);
`ifdef SPI_MASTER_ABORT_EN
        abort_hit = abort && (state != IDLE) && (state != GAP);
`endif
    end

    spi_shift_reg #(
        .FRAME_W (FRAME_W),
        .DATA_W  (DATA_W)
    ) u_shift (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .shift_tx (shift_tx),
        .shift_rx (shift_rx),
        .tx_word  (tx_word),
        .miso     (MISO),
        .tx_msb   (tx_msb),
        .rx_next  (rx_next)
    );

    // Frame sequencer with registered SS_n/MOSI and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            cmd      <= CMD_WR_ADDR;
            SS_n     <= 1'b1;
            MOSI     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
`ifdef SPI_MASTER_ABORT_EN
            aborted  <= 1'b0;
`endif
        end else begin
            done     <= 1'b0;
            rd_valid <= 1'b0;
`ifdef SPI_MASTER_ABORT_EN
            if (abort_hit) begin
                state   <= GAP;
                cnt     <= GAP_LOAD;
                SS_n    <= 1'b1;
                MOSI    <= 1'b0;
                done    <= 1'b1;
                aborted <= 1'b1;
            end else begin
`else
            begin
`endif
                case (state)
                    IDLE: begin
                        if (accept) begin
                            state <= ARM;
                            cmd   <= tx_word[FRAME_W-1 -: 2];
                            SS_n  <= 1'b0;
                            MOSI  <= 1'b0;
                            busy  <= 1'b1;
`ifdef SPI_MASTER_ABORT_EN
                            aborted <= 1'b0;
`endif
                        end
                    end
                    ARM: begin
                        state <= SEL;
                        MOSI  <= tx_msb;
                    end
                    SEL: begin
                        state <= SHIFT;
                        cnt   <= SHIFT_LOAD;
                        MOSI  <= tx_msb;
                    end
                    SHIFT: begin
                        if (cnt != 4'd0) begin
                            cnt  <= cnt - 4'd1;
                            MOSI <= tx_msb;
                        end else if (cmd == CMD_RD_DATA) begin
                            state <= WAIT;
                            cnt   <= WAIT_LOAD;
                            MOSI  <= 1'b0;
                        end else begin
                            state <= GAP;
                            cnt   <= GAP_LOAD;
                            SS_n  <= 1'b1;
                            MOSI  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                    WAIT: begin
                        if (cnt != 4'd0) begin
                            cnt <= cnt - 4'd1;
                        end else begin
                            state <= READ;
                            cnt   <= READ_LOAD;
                        end
                    end
                    READ: begin
                        if (cnt != 4'd0) begin
                            cnt <= cnt - 4'd1;
                        end else begin
                            state    <= GAP;
                            cnt      <= GAP_LOAD;
                            SS_n     <= 1'b1;
                            done     <= 1'b1;
                            rd_valid <= 1'b1;
                            rd_data  <= rx_next;
                        end
                    end
                    GAP: begin
                        if (cnt != 4'd0) begin
                            cnt <= cnt - 4'd1;
                        end else if (accept) begin
                            state <= ARM;
                            cmd   <= tx_word[FRAME_W-1 -: 2];
                            SS_n  <= 1'b0;
                            MOSI  <= 1'b0;
`ifdef SPI_MASTER_ABORT_EN
                            aborted <= 1'b0;
`endif
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
